utopia_rx_cell_arbiter: RTL and testbench
=========================================

Name: utopia_rx_cell_arbiter

Overview:
Round-robin scheduler that shares the switch's single cell-forwarding datapath among the NumRx Utopia receive ports. Each Rx port raises a request when it holds a complete buffered cell. The arbiter grants one port, sequences exactly CellBytes byte transfers into the forwarding path under downstream backpressure, marks SOP/EOP, then releases. It sits between the Rx Utopia port blocks and the squat forwarding core. Port enables come from the management (cpu_ifc) register bank.

Parameters:
NumRx, 4, number of Utopia receive ports/requesters.
CellBytes, 53, bytes per ATM cell transfer.
CntW, 16, width of forwarded-cell and abort statistics counters.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous reset, active-high.
req  in  NumRx  per-port "complete cell available" request.
port_en  in  NumRx  per-port enable from management registers; disabled ports are never granted.
src_valid  in  1  granted port's current byte is valid.
fwd_ready  in  1  forwarding datapath accepts a byte this cycle.
grant  out  NumRx  one-hot registered grant; all-zero when idle.
grant_id  out  $clog2(NumRx)  index of granted port; holds last value when idle.
busy  out  1  high in XFER.
byte_take  out  1  src_valid & fwd_ready & (state==XFER); byte accepted this cycle.
sop  out  1  byte_take on byte index 0.
eop  out  1  byte_take on byte index CellBytes-1.
abort  out  1  one-cycle pulse when a transfer is cut short.
cell_cnt  out  CntW  completed cells, saturating.
abort_cnt  out  CntW  aborted transfers, saturating.

Behaviour:
- Reset (sync, rst=1 at a clk edge): state=IDLE, grant=0, grant_id=0, rr pointer=0, byte index=0, busy=0, abort=0, cell_cnt=0, abort_cnt=0. byte_take/sop/eop are 0 because state≠XFER. Reset mid-cell drops the transfer silently: no abort pulse, no counter change.
- States: IDLE, XFER, GAP.
- IDLE: eligible = req & port_en. If nonzero, pick the first set bit searching from rr pointer upward with wrap. Register grant/grant_id and enter XFER on the next edge. Grant latency is 1 cycle from the sampled request. If eligible is zero, stay in IDLE.
- XFER: each byte_take increments the byte index (0..CellBytes-1). Backpressure (src_valid=0 or fwd_ready=0) stalls with no other effect and no timeout.
- Completion: eop at byte index CellBytes-1. On that edge: cell_cnt += 1 (saturate at all-ones), rr pointer = grant_id+1 mod NumRx, index=0, grant cleared, enter GAP.
- Abort: in XFER, if req[grant_id]=0 or port_en[grant_id]=0 in a cycle without eop, then:
  - abort=1 that cycle (combinational, registered-state qualified);
  - on the edge: abort_cnt += 1 (saturate), rr pointer = grant_id+1, index=0, grant cleared, enter GAP;
  - byte_take is still honoured that cycle but does not count toward a cell.
- Simultaneous eop and request/enable drop: eop wins, completion path, no abort.
- GAP: exactly one idle cycle (grant=0, busy=0), then IDLE. Guarantees at least 2 cycles between the EOP cycle and the next grant.
- Fairness: with all ports continuously eligible, grants rotate 0,1,2,...,NumRx-1,0. A port whose enable is cleared while not granted is skipped without disturbing the pointer.
- grant stays one-hot or zero at all times. grant_id is stable throughout XFER.
- Counters wrap never. They saturate at 2^CntW-1 and hold.

Test Plan:
- req=0100, port_en=1111, src_valid=fwd_ready=1 → grant=0100 one cycle after req. 53 consecutive byte_take. sop on the 1st, eop on the 53rd. cell_cnt=1. One GAP cycle, then IDLE.
- req=1111 held, full throughput → grant sequence 0001,0010,0100,1000,0001. Each holds exactly 53 takes. cell_cnt=5 after five cells.
- req=1111, port_en=1011 → port 2 never granted. Order is 0,1,3,0.
- Port 1 granted with fwd_ready toggling 1,0,1,0 and src_valid low every 3rd cycle → exactly 53 byte_take, eop on the 53rd take, no abort.
- Port 3 granted, req[3] dropped after 20 takes → abort pulse that cycle, abort_cnt=1, cell_cnt unchanged, next grant goes to port 0 if it is requesting. Second case: req drop coincident with the 53rd take → eop, cell_cnt+1, no abort.
- rst=1 at take 30 of a cell → next cycle grant=0, busy=0, abort=0, counters 0. Same requests after rst release → port 0 granted first.

Source files
------------

// File: rtl/utopia_rx_cell_arbiter.sv
// Round-robin arbiter sharing one cell-forwarding datapath among NumRx Utopia Rx ports.
// Latency: grant registered 1 cycle after an eligible request is sampled; one GAP cycle after each cell.
// Backpressure: src_valid_i/fwd_ready_i low stalls the byte sequence indefinitely, with no other effect.
module utopia_rx_cell_arbiter #(
    parameter int NumRx     = 4,
    parameter int CellBytes = 53,
    parameter int CntW      = 16,
    localparam int IdW      = (NumRx > 1) ? $clog2(NumRx) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NumRx-1:0] req_i,
    input  logic [NumRx-1:0] port_en_i,
    input  logic             src_valid_i,
    input  logic             fwd_ready_i,
    output logic [NumRx-1:0] grant_o,
    output logic [IdW-1:0]   grant_id_o,
    output logic             busy_o,
    output logic             byte_take_o,
    output logic             sop_o,
    output logic             eop_o,
    output logic             abort_o,
    output logic [CntW-1:0]  cell_cnt_o,
    output logic [CntW-1:0]  abort_cnt_o
);

    localparam int IxW = (CellBytes > 1) ? $clog2(CellBytes) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [NumRx-1:0] grant_q, grant_d;
    logic [IdW-1:0]   grant_id_q, grant_id_d;
    logic [IdW-1:0]   rr_q, rr_d;
    logic [IxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]  cell_cnt_q, cell_cnt_d;
    logic [CntW-1:0]  abort_cnt_q, abort_cnt_d;

    logic [NumRx-1:0] eligible;
    logic             pick_vld;
    logic [IdW-1:0]   pick_id;
    logic [IdW:0]     pick_sum;
    logic [IdW-1:0]   rr_next;
    logic             in_xfer;
    logic             take;
    logic             last_byte;
    logic             cell_done;
    logic             src_lost;
    logic             cut_short;

    assign eligible  = req_i & port_en_i;
    assign in_xfer   = (state_q == XFER);
    assign take      = src_valid_i & fwd_ready_i & in_xfer;
    assign last_byte = (idx_q == IxW'(CellBytes - 1));
    assign cell_done = take & last_byte;
    // The granted source vanishing (request withdrawn or port disabled) ends the cell early,
    // unless this very cycle carries the final byte.
    assign src_lost  = ~req_i[grant_id_q] | ~port_en_i[grant_id_q];
    assign cut_short = in_xfer & src_lost & ~cell_done;
    assign rr_next   = (grant_id_q == IdW'(NumRx - 1)) ? '0 : grant_id_q + 1'b1;

    // Find the first eligible port at or above the round-robin pointer, wrapping around.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        pick_sum = '0;
        for (int i = 0; i < NumRx; i++) begin
            pick_sum = {1'b0, rr_q} + (IdW + 1)'(i);
            if (pick_sum >= (IdW + 1)'(NumRx)) begin
                pick_sum = pick_sum - (IdW + 1)'(NumRx);
            end
            if (!pick_vld && eligible[pick_sum[IdW-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = pick_sum[IdW-1:0];
            end
        end
    end

    // Next-state logic: grant selection, byte sequencing, completion/abort bookkeeping.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        rr_d        = rr_q;
        idx_d       = idx_q;
        cell_cnt_d  = cell_cnt_q;
        abort_cnt_d = abort_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d          = '0;
                    grant_d[pick_id] = 1'b1;
                    grant_id_d       = pick_id;
                    idx_d            = '0;
                    state_d          = XFER;
                end
            end
            XFER: begin
                if (cell_done) begin
                    cell_cnt_d = (cell_cnt_q == '1) ? cell_cnt_q : cell_cnt_q + 1'b1;
                    rr_d       = rr_next;
                    idx_d      = '0;
                    grant_d    = '0;
                    state_d    = GAP;
                end else if (cut_short) begin
                    abort_cnt_d = (abort_cnt_q == '1) ? abort_cnt_q : abort_cnt_q + 1'b1;
                    rr_d        = rr_next;
                    idx_d       = '0;
                    grant_d     = '0;
                    state_d     = GAP;
                end else if (take) begin
                    idx_d = idx_q + 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; reset mid-cell silently drops the transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            rr_q        <= '0;
            idx_q       <= '0;
            cell_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            rr_q        <= rr_d;
            idx_q       <= idx_d;
            cell_cnt_q  <= cell_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign grant_o     = grant_q;
    assign grant_id_o  = grant_id_q;
    assign busy_o      = in_xfer;
    assign byte_take_o = take;
    assign sop_o       = take & (idx_q == '0);
    assign eop_o       = cell_done;
    assign abort_o     = cut_short;
    assign cell_cnt_o  = cell_cnt_q;
    assign abort_cnt_o = abort_cnt_q;

endmodule

// File: tb/tb_utopia_rx_cell_arbiter.sv
// Directed bench for utopia_rx_cell_arbiter: reset, single cell, rotation, disabled port,
// backpressure, abort vs. eop race, and reset in the middle of a cell.
module tb_utopia_rx_cell_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  port_en;
    logic        src_valid;
    logic        fwd_ready;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        busy;
    logic        byte_take;
    logic        sop;
    logic        eop;
    logic        abort;
    logic [15:0] cell_cnt;
    logic [15:0] abort_cnt;

    int errors = 0;
    int checks = 0;

    utopia_rx_cell_arbiter #(.NumRx(4), .CellBytes(53), .CntW(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .port_en_i   (port_en),
        .src_valid_i (src_valid),
        .fwd_ready_i (fwd_ready),
        .grant_o     (grant),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .byte_take_o (byte_take),
        .sop_o       (sop),
        .eop_o       (eop),
        .abort_o     (abort),
        .cell_cnt_o  (cell_cnt),
        .abort_cnt_o (abort_cnt)
    );

    always #5 clk = ~clk;

    // Leaves the bench 2 time units after a clock edge with the DUT in IDLE.
    task automatic do_reset();
        rst       = 1'b1;
        req       = 4'b0000;
        port_en   = 4'b1111;
        src_valid = 1'b0;
        fwd_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
    endtask

    // Counts clock edges until grant becomes nonzero, bounded by budget.
    task automatic wait_grant(input int budget, output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        while (!ok && cyc < budget) begin
            @(posedge clk);
            #2;
            cyc++;
            if (grant !== 4'b0000) ok = 1'b1;
        end
    endtask

    // Drives the handshake for one whole transfer and records what the DUT did.
    // mode 0: full throughput; mode 1: fwd_ready toggles 1,0,.. and src_valid low every 3rd cycle.
    // When drop_at equals the take count, req[drop_port] is withdrawn in that cycle.
    task automatic run_xfer(input int mode, input int drop_at, input int drop_port, input int budget,
                            output int takes, output int cycles,
                            output int n_sop, output int sop_pos,
                            output int n_eop, output int eop_pos,
                            output int n_abort, output int abort_pos);
        takes = 0; cycles = 0;
        n_sop = 0; sop_pos = -1;
        n_eop = 0; eop_pos = -1;
        n_abort = 0; abort_pos = -1;
        while (busy === 1'b1 && cycles < budget) begin
            if (mode == 0) begin
                src_valid = 1'b1;
                fwd_ready = 1'b1;
            end else begin
                fwd_ready = (cycles % 2 == 0);
                src_valid = (cycles % 3 != 2);
            end
            if (takes == drop_at) req[drop_port] = 1'b0;
            #1;
            if (sop === 1'b1) begin n_sop++; sop_pos = takes; end
            if (eop === 1'b1) begin n_eop++; eop_pos = takes; end
            if (abort === 1'b1) begin n_abort++; abort_pos = takes; end
            if (byte_take === 1'b1) takes++;
            @(posedge clk);
            #2;
            cycles++;
        end
        src_valid = 1'b0;
        fwd_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({byte_take, sop, eop, abort} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {byte_take, sop, eop, abort}); end
        checks++; if (cell_cnt !== 16'd0) begin errors++; $display("FAIL reset_cell_cnt: got %0d want 0", cell_cnt); end
        checks++; if (abort_cnt !== 16'd0) begin errors++; $display("FAIL reset_abort_cnt: got %0d want 0", abort_cnt); end
    endtask

    task automatic test_single_cell();
        int cyc, tk, cy, ns, sp, ne, ep, na, ap;
        bit ok;
        do_reset();
        req = 4'b0100;
        wait_grant(10, cyc, ok);
        checks++; if (!ok || cyc != 1) begin errors++; $display("FAIL single_grant_latency: got %0d edges (ok=%0d) want 1", cyc, ok); end
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
        run_xfer(0, -1, 0, 200, tk, cy, ns, sp, ne, ep, na, ap);
        checks++; if (tk != 53 || cy != 53) begin errors++; $display("FAIL single_takes: got %0d takes in %0d cycles want 53 in 53", tk, cy); end
        checks++; if (ns != 1 || sp != 0) begin errors++; $display("FAIL single_sop: got count %0d at %0d want 1 at 0", ns, sp); end
        checks++; if (ne != 1 || ep != 52) begin errors++; $display("FAIL single_eop: got count %0d at %0d want 1 at 52", ne, ep); end
        checks++; if (na != 0) begin errors++; $display("FAIL single_abort: got %0d want 0", na); end
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL single_gap: got busy=%b grant=%b want 0 0000", busy, grant); end
        checks++; if (cell_cnt !== 16'd1) begin errors++; $display("FAIL single_cell_cnt: got %0d want 1", cell_cnt); end
        checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_id_hold: got %0d want 2", grant_id); end
        req = 4'b0000;
        @(posedge clk);
        #2;
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL single_idle: got busy=%b grant=%b want 0 0000", busy, grant); end
    endtask

    task automatic test_round_robin();
        int cyc, tk, cy, ns, sp, ne, ep, na, ap;
        bit ok;
        logic [3:0] want;
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            want = 4'b0001 << (c % 4);
            wait_grant(10, cyc, ok);
            checks++; if (!ok || cyc != ((c == 0) ? 1 : 2)) begin errors++; $display("FAIL rr_latency[%0d]: got %0d edges want %0d", c, cyc, (c == 0) ? 1 : 2); end
            checks++; if (grant !== want) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, grant, want); end
            run_xfer(0, -1, 0, 200, tk, cy, ns, sp, ne, ep, na, ap);
            checks++; if (tk != 53 || ne != 1 || na != 0) begin errors++; $display("FAIL rr_cell[%0d]: got takes=%0d eop=%0d abort=%0d want 53 1 0", c, tk, ne, na); end
        end
        checks++; if (cell_cnt !== 16'd5) begin errors++; $display("FAIL rr_cell_cnt: got %0d want 5", cell_cnt); end
        req = 4'b0000;
    endtask

    task automatic test_port_disable();
        int cyc, tk, cy, ns, sp, ne, ep, na, ap;
        bit ok;
        logic [3:0] order [4];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0001;
        do_reset();
        port_en = 4'b1011;
        req     = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            wait_grant(10, cyc, ok);
            checks++; if (!ok || grant !== order[c]) begin errors++; $display("FAIL dis_grant[%0d]: got %b want %b", c, grant, order[c]); end
            run_xfer(0, -1, 0, 200, tk, cy, ns, sp, ne, ep, na, ap);
            checks++; if (tk != 53 || na != 0) begin errors++; $display("FAIL dis_cell[%0d]: got takes=%0d abort=%0d want 53 0", c, tk, na); end
        end
        checks++; if (cell_cnt !== 16'd4 || abort_cnt !== 16'd0) begin errors++; $display("FAIL dis_counts: got cells=%0d aborts=%0d want 4 0", cell_cnt, abort_cnt); end
        req = 4'b0000;
    endtask

    task automatic test_backpressure();
        int cyc, tk, cy, ns, sp, ne, ep, na, ap;
        bit ok;
        do_reset();
        req = 4'b0010;
        wait_grant(10, cyc, ok);
        checks++; if (!ok || grant !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", grant); end
        run_xfer(1, -1, 0, 400, tk, cy, ns, sp, ne, ep, na, ap);
        checks++; if (tk != 53) begin errors++; $display("FAIL bp_takes: got %0d want 53", tk); end
        checks++; if (cy != 157) begin errors++; $display("FAIL bp_cycles: got %0d want 157", cy); end
        checks++; if (ne != 1 || ep != 52 || ns != 1 || sp != 0) begin errors++; $display("FAIL bp_sop_eop: got sop=%0d@%0d eop=%0d@%0d want 1@0 1@52", ns, sp, ne, ep); end
        checks++; if (na != 0 || abort_cnt !== 16'd0) begin errors++; $display("FAIL bp_abort: got pulses=%0d cnt=%0d want 0 0", na, abort_cnt); end
        checks++; if (cell_cnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL bp_done: got cells=%0d busy=%b want 1 0", cell_cnt, busy); end
        req = 4'b0000;
    endtask

    task automatic test_abort();
        int cyc, tk, cy, ns, sp, ne, ep, na, ap;
        bit ok;
        do_reset();
        req = 4'b1000;
        wait_grant(10, cyc, ok);
        checks++; if (!ok || grant !== 4'b1000 || grant_id !== 2'd3) begin errors++; $display("FAIL ab_grant: got %b id=%0d want 1000 id=3", grant, grant_id); end
        req = 4'b1001;
        run_xfer(0, 20, 3, 200, tk, cy, ns, sp, ne, ep, na, ap);
        checks++; if (na != 1 || ap != 20) begin errors++; $display("FAIL ab_pulse: got count %0d at %0d want 1 at 20", na, ap); end
        checks++; if (tk != 21 || ne != 0) begin errors++; $display("FAIL ab_takes: got takes=%0d eop=%0d want 21 0", tk, ne); end
        checks++; if (abort_cnt !== 16'd1 || cell_cnt !== 16'd0) begin errors++; $display("FAIL ab_counts: got aborts=%0d cells=%0d want 1 0", abort_cnt, cell_cnt); end
        checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin errors++; $display("FAIL ab_gap: got busy=%b grant=%b want 0 0000", busy, grant); end
        wait_grant(10, cyc, ok);
        checks++; if (!ok || cyc != 2 || grant !== 4'b0001) begin errors++; $display("FAIL ab_next_grant: got %b after %0d edges want 0001 after 2", grant, cyc); end
        run_xfer(0, -1, 0, 200, tk, cy, ns, sp, ne, ep, na, ap);
        checks++; if (tk != 53 || cell_cnt !== 16'd1) begin errors++; $display("FAIL ab_port0_cell: got takes=%0d cells=%0d want 53 1", tk, cell_cnt); end
        req = 4'b1000;
        wait_grant(10, cyc, ok);
        checks++; if (!ok || grant !== 4'b1000) begin errors++; $display("FAIL race_grant: got %b want 1000", grant); end
        run_xfer(0, 52, 3, 200, tk, cy, ns, sp, ne, ep, na, ap);
        checks++; if (ne != 1 || ep != 52 || na != 0) begin errors++; $display("FAIL race_eop_wins: got eop=%0d@%0d abort=%0d want 1@52 0", ne, ep, na); end
        checks++; if (cell_cnt !== 16'd2 || abort_cnt !== 16'd1) begin errors++; $display("FAIL race_counts: got cells=%0d aborts=%0d want 2 1", cell_cnt, abort_cnt); end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_cell();
        int cyc, tk, cy, ns, sp, ne, ep, na, ap;
        bit ok;
        do_reset();
        req = 4'b0010;
        wait_grant(10, cyc, ok);
        run_xfer(0, -1, 0, 200, tk, cy, ns, sp, ne, ep, na, ap);
        req = 4'b1111;
        wait_grant(10, cyc, ok);
        checks++; if (!ok || grant !== 4'b0100) begin errors++; $display("FAIL mid_pre_grant: got %b want 0100", grant); end
        src_valid = 1'b1;
        fwd_ready = 1'b1;
        for (int i = 0; i < 29; i++) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b1;
        #1;
        checks++; if (byte_take !== 1'b1 || abort !== 1'b0) begin errors++; $display("FAIL mid_take30: got take=%b abort=%b want 1 0", byte_take, abort); end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (grant !== 4'b0000 || busy !== 1'b0 || abort !== 1'b0) begin errors++; $display("FAIL mid_after_rst: got grant=%b busy=%b abort=%b want 0000 0 0", grant, busy, abort); end
        checks++; if (cell_cnt !== 16'd0 || abort_cnt !== 16'd0 || grant_id !== 2'd0) begin errors++; $display("FAIL mid_counts: got cells=%0d aborts=%0d id=%0d want 0 0 0", cell_cnt, abort_cnt, grant_id); end
        wait_grant(10, cyc, ok);
        checks++; if (!ok || cyc != 1 || grant !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b after %0d edges want 0001 after 1", grant, cyc); end
        src_valid = 1'b0;
        fwd_ready = 1'b0;
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_cell();
        test_round_robin();
        test_port_disable();
        test_backpressure();
        test_abort();
        test_reset_mid_cell();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
